tap_window: RTL and testbench
=============================

# tap_window

Multi-channel, decimating tap delay line for the FIR accelerator; next generation of the single-channel shift register. It accepts a time-multiplexed sample stream (one channel per sample) over a valid/ready handshake and keeps an independent DEPTH-tap history per channel. Once a channel's history is full, it presents that channel's full tap window to the MAC stage, also over valid/ready, every DECIM-th sample. It sits between the sensor front end and the coefficient multiply/accumulate block.

## Interface
- DATA_WIDTH, 16, sample width in bits
- DEPTH, 8, taps per channel (≥2)
- NUM_CH, 2, channel count (≥1); CH_W = max(1, $clog2(NUM_CH))
- DECIM, 1, output decimation factor (≥1)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all history, counters and pending output
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample this cycle
- in_ch  in  CH_W  channel of the sample
- in_data  in  DATA_WIDTH  sample value
- out_valid  out  1  tap window present
- out_ready  in  1  consumer takes the window this cycle
- out_ch  out  CH_W  channel the window belongs to
- out_taps  out  DEPTH×DATA_WIDTH  window; out_taps[0] newest, out_taps[DEPTH-1] oldest
- primed  out  NUM_CH  per-channel flag: history full (fill == DEPTH)

## Operation
- Accept = in_valid && in_ready && !flush. in_ready = !out_valid || out_ready (combinational from out_ready, by design).
- On accept to channel c (c < NUM_CH): taps[c] shift by one toward the oldest tap; in_data enters tap 0; the oldest tap is discarded. Other channels are untouched.
- An accept with in_ch ≥ NUM_CH is consumed and dropped: no state change, no output.
- fill[c] counts 0..DEPTH and saturates. phase[c] counts 0..DECIM-1 and wraps.
- Emit rule: the accept that takes fill[c] from DEPTH-1 to DEPTH emits and sets phase[c] = 1 mod DECIM. Later accepts with fill[c] == DEPTH emit iff phase[c] == 0, then set phase[c] = (phase[c]+1) mod DECIM. Accepts with fill < DEPTH never emit.
- Emit registers out_valid = 1 and out_ch = c. out_taps is a combinational mux of the live taps[out_ch]. Those taps stay stable while out_valid is high and out_ready is low, because in_ready is then low.
- out_valid clears on out_ready unless a new emit occurs in the same cycle. A simultaneous emit reloads out_ch, so back-to-back windows run at full rate.
- flush (priority over accept): all taps, fill and phase become 0, out_valid becomes 0, out_ch becomes 0. An in-flight window is dropped.

## Timing
- Reset (rst low, async): all taps 0, fill 0, phase 0, out_valid 0, out_ch 0, primed 0. in_ready is then 1.
- Latency: accept at edge N → out_valid high after edge N, with the window including that sample.
- primed[c] rises after the edge of the DEPTH-th accept to c.
- Throughput: one sample per cycle when out_ready is held high.
- Reset mid-operation: state is lost immediately; the first window after release needs DEPTH fresh samples.
- Flush and out_ready in the same cycle: the window is considered consumed; flush still clears.

## Structure
- Shared package fir_pkg: DATA_WIDTH/NUM_REGS defaults, sample_t typedef, CH_W helper function.
- Sub-module tap_line: one channel's DEPTH-tap shift line with shift-enable and synchronous clear, parallel tap output; instantiated NUM_CH times. Counters, emit logic and the output mux live in tap_window.

## Test plan
- Fill, NUM_CH=1, DEPTH=8, DECIM=1, out_ready=1: feed 1..10 → first out_valid after sample 8 with out_taps = 8,7,…,1, then one window per sample; the last is 10..3.
- Interleave, NUM_CH=2: alternate ch0 = 1,2,… and ch1 = 101,102,… for 8 samples each → the ch0 window 8..1 and the ch1 window 108..101 appear on consecutive cycles with the correct out_ch; no cross-channel mixing.
- Decimation, DECIM=3, ch0 fed 1..14 → windows after samples 8, 11 and 14 only.
- Backpressure: hold out_ready=0 after the first window → in_ready=0, out_taps stable, extra in_valid ignored; release → window consumed, next sample accepted on the same cycle.
- Flush after 5 samples, then 8 more samples → no window before the 8th post-flush sample; primed = 0 right after flush; the window holds only post-flush values.
- Async reset mid-stream (rst low between edges): outputs drop to reset values immediately; in_ch = NUM_CH (NUM_CH=3) is dropped with no output.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR accelerator datapath: default sizes,
// the sample type and the channel-index width helper.
package fir_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int NUM_REGS_DEF   = 8;

    typedef logic [DATA_WIDTH_DEF-1:0] sample_t;

    // Channel-index width; a single channel still needs one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tap_window_if.sv
// Sample-in / window-out handshake bundle of tap_window.
interface tap_window_if
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = NUM_REGS_DEF,
    parameter int NUM_CH     = 2
) ();

    localparam int CH_W = ch_w(NUM_CH);

    logic                             in_valid;
    logic                             in_ready;
    logic [CH_W-1:0]                  in_ch;
    logic [DATA_WIDTH-1:0]            in_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [CH_W-1:0]                  out_ch;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] out_taps;
    logic [NUM_CH-1:0]                primed;

    // The tap window block itself.
    modport slave (
        input  in_valid, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_ch, out_taps, primed
    );

    // Sample producer plus window consumer.
    modport master (
        output in_valid, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_ch, out_taps, primed
    );

endinterface

// File: rtl/tap_window_line.sv
// One channel's DEPTH-tap shift line; tap 0 holds the newest sample.
module tap_line
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = NUM_REGS_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_clr,
    input  logic                             i_shift,
    input  logic [DATA_WIDTH-1:0]            i_data,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0] o_taps
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_taps;

    // Shift toward the oldest tap on each accepted sample; clear on flush.
    // NOTE: the taps are flops, not a RAM, so they take the async reset; the
    // window must read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_taps <= '0;
        end else if (i_clr) begin
            r_taps <= '0;
        end else if (i_shift) begin
            r_taps <= {r_taps[DEPTH-2:0], i_data};
        end
    end

    assign o_taps = r_taps;

endmodule

// File: rtl/tap_window.sv
// Multi-channel decimating tap delay line: keeps a DEPTH-tap history per
// channel and hands a full window to the MAC stage every DECIM-th sample.
module tap_window
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = NUM_REGS_DEF,
    parameter int NUM_CH     = 2,
    parameter int DECIM      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    tap_window_if.slave  bus
);

    localparam int CH_W   = ch_w(NUM_CH);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

    logic                             w_in_ready;
    logic                             w_accept;
    logic [NUM_CH-1:0]                w_hit;
    logic [NUM_CH-1:0]                w_emit;
    logic [NUM_CH-1:0]                w_primed;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] w_taps [NUM_CH];
    logic [DEPTH-1:0][DATA_WIDTH-1:0] w_out_taps;
    logic                             r_out_valid;
    logic [CH_W-1:0]                  r_out_ch;

    function automatic logic [PH_W-1:0] ph_next(input logic [PH_W-1:0] p);
        return (int'(p) == DECIM - 1) ? '0 : p + 1'b1;
    endfunction

    // A held window freezes the input so its taps cannot move underneath it.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready && !flush;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [FILL_W-1:0] r_fill;
        logic [PH_W-1:0]   r_phase;

        // An out-of-range channel matches no line, so it is consumed silently.
        assign w_hit[c]    = w_accept && (bus.in_ch == CH_W'(c));
        assign w_emit[c]   = w_hit[c] &&
                             ((r_fill == FILL_LAST) ||
                              ((r_fill == FILL_FULL) && (r_phase == '0)));
        assign w_primed[c] = (r_fill == FILL_FULL);

        tap_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_line (
            .clk     (clk),
            .rst     (rst),
            .i_clr   (flush),
            .i_shift (w_hit[c]),
            .i_data  (bus.in_data),
            .o_taps  (w_taps[c])
        );

        // Saturating fill count and decimation phase; the filling sample
        // emits and starts the phase at 1 so the next emit is DECIM later.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_fill  <= '0;
                r_phase <= '0;
            end else if (flush) begin
                r_fill  <= '0;
                r_phase <= '0;
            end else if (w_hit[c]) begin
                if (r_fill == FILL_LAST) begin
                    r_fill  <= FILL_FULL;
                    r_phase <= ph_next('0);
                end else if (r_fill == FILL_FULL) begin
                    r_phase <= ph_next(r_phase);
                end else begin
                    r_fill  <= r_fill + 1'b1;
                end
            end
        end
    end

    // Output handshake: a new emit wins over consumption so windows can
    // run back to back; flush drops whatever is pending.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
        end else if (|w_emit) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= bus.in_ch;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Window mux over the live taps of the selected channel.
    // NOTE: the default assignment up front keeps this purely combinational.
    always_comb begin
        w_out_taps = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_out_ch == CH_W'(c)) begin
                w_out_taps = w_taps[c];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_taps  = w_out_taps;
    assign bus.primed    = w_primed;

endmodule

// File: tb/tb_tap_window.sv
// Directed bench for tap_window: instance A (3 channels, no decimation)
// covers fill, interleave, backpressure, flush, bad channel and async reset;
// instance B (1 channel, DECIM=3) covers decimation.
module tb_tap_window;
    import fir_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic a_flush;
    logic b_flush;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    tap_window_if #(.DATA_WIDTH(16), .DEPTH(8), .NUM_CH(3)) a_if ();
    tap_window_if #(.DATA_WIDTH(16), .DEPTH(8), .NUM_CH(1)) b_if ();

    tap_window #(.DATA_WIDTH(16), .DEPTH(8), .NUM_CH(3), .DECIM(1)) u_a (
        .clk   (clk),
        .rst   (rst),
        .flush (a_flush),
        .bus   (a_if)
    );

    tap_window #(.DATA_WIDTH(16), .DEPTH(8), .NUM_CH(1), .DECIM(3)) u_b (
        .clk   (clk),
        .rst   (rst),
        .flush (b_flush),
        .bus   (b_if)
    );

    // Expected window whose newest sample is 'newest' and which steps down by one.
    function automatic logic [127:0] win(input int newest);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            w[k*16 +: 16] = 16'(newest - k);
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        a_flush = 1'b0;
        b_flush = 1'b0;
        a_if.in_valid = 1'b0; a_if.in_ch = '0; a_if.in_data = '0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_ch = '0; b_if.in_data = '0; b_if.out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", a_if.out_valid, 0);
        check("rst_in_ready", a_if.in_ready, 1);
        check("rst_primed", a_if.primed, 0);
        check("rst_out_ch", a_if.out_ch, 0);
        check("rst_taps", a_if.out_taps, 0);
        rst = 1'b1;

        // Fill ch0 with 1..10: first window after sample 8, then every sample
        for (int i = 1; i <= 10; i++) begin
            a_if.in_valid = 1'b1; a_if.in_ch = 2'd0; a_if.in_data = sample_t'(i);
            tick();
            check("fill_valid", a_if.out_valid, (i >= 8) ? 1 : 0);
            if (i >= 8) begin
                check("fill_taps", a_if.out_taps, win(i));
                check("fill_ch", a_if.out_ch, 0);
            end
            if (i == 7) check("fill_primed7", a_if.primed, 3'b000);
            if (i == 8) check("fill_primed8", a_if.primed, 3'b001);
        end
        a_if.in_valid = 1'b0;
        tick();
        check("fill_drain", a_if.out_valid, 0);

        // Flush clears everything
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("flush_primed", a_if.primed, 0);
        check("flush_valid", a_if.out_valid, 0);
        check("flush_taps", a_if.out_taps, 0);

        // Interleave ch0 = 1..8 and ch1 = 101..108
        for (int k = 1; k <= 8; k++) begin
            a_if.in_valid = 1'b1; a_if.in_ch = 2'd0; a_if.in_data = sample_t'(k);
            tick();
            check("il_valid0", a_if.out_valid, (k == 8) ? 1 : 0);
            if (k == 8) begin
                check("il_ch0", a_if.out_ch, 0);
                check("il_taps0", a_if.out_taps, win(8));
            end
            a_if.in_ch = 2'd1; a_if.in_data = sample_t'(100 + k);
            tick();
            check("il_valid1", a_if.out_valid, (k == 8) ? 1 : 0);
            if (k == 8) begin
                check("il_ch1", a_if.out_ch, 1);
                check("il_taps1", a_if.out_taps, win(108));
            end
        end
        check("il_primed", a_if.primed, 3'b011);

        // Backpressure: window on ch0 held while out_ready is low
        a_if.in_ch = 2'd0; a_if.in_data = 16'd9;
        tick();
        check("bp_valid", a_if.out_valid, 1);
        check("bp_ch", a_if.out_ch, 0);
        check("bp_taps", a_if.out_taps, win(9));
        a_if.out_ready = 1'b0;
        a_if.in_ch = 2'd1; a_if.in_data = 16'd109;
        #1;
        check("bp_in_ready_low", a_if.in_ready, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("bp_hold_valid", a_if.out_valid, 1);
            check("bp_hold_ch", a_if.out_ch, 0);
            check("bp_hold_taps", a_if.out_taps, win(9));
        end
        a_if.out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", a_if.in_ready, 1);
        tick();
        check("bp_rel_valid", a_if.out_valid, 1);
        check("bp_rel_ch", a_if.out_ch, 1);
        check("bp_rel_taps", a_if.out_taps, win(109));
        a_if.in_valid = 1'b0;
        tick();
        check("bp_drain", a_if.out_valid, 0);

        // Flush after 5 samples on ch2, then 8 fresh samples
        for (int k = 1; k <= 5; k++) begin
            a_if.in_valid = 1'b1; a_if.in_ch = 2'd2; a_if.in_data = sample_t'(k);
            tick();
        end
        a_if.in_valid = 1'b0;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("fl_primed", a_if.primed, 0);
        for (int k = 1; k <= 8; k++) begin
            a_if.in_valid = 1'b1; a_if.in_ch = 2'd2; a_if.in_data = sample_t'(200 + k);
            tick();
            check("fl_valid", a_if.out_valid, (k == 8) ? 1 : 0);
            if (k == 8) begin
                check("fl_ch", a_if.out_ch, 2);
                check("fl_taps", a_if.out_taps, win(208));
                check("fl_primed8", a_if.primed, 3'b100);
            end
        end

        // Flush together with out_ready while a window is pending
        a_if.in_valid = 1'b0;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("flr_valid", a_if.out_valid, 0);
        check("flr_ch", a_if.out_ch, 0);
        check("flr_primed", a_if.primed, 0);

        // Out-of-range channel is consumed and dropped
        for (int k = 1; k <= 7; k++) begin
            a_if.in_valid = 1'b1; a_if.in_ch = 2'd0; a_if.in_data = sample_t'(300 + k);
            tick();
        end
        a_if.in_ch = 2'd3; a_if.in_data = 16'hDEAD;
        #1;
        check("bad_in_ready", a_if.in_ready, 1);
        tick();
        check("bad_valid", a_if.out_valid, 0);
        check("bad_primed", a_if.primed, 0);
        a_if.in_ch = 2'd0; a_if.in_data = 16'd308;
        tick();
        check("bad_next_valid", a_if.out_valid, 1);
        check("bad_next_taps", a_if.out_taps, win(308));

        // Async reset between edges with a window pending
        a_if.in_valid = 1'b0;
        a_if.out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", a_if.out_valid, 0);
        check("ar_ch", a_if.out_ch, 0);
        check("ar_primed", a_if.primed, 0);
        check("ar_in_ready", a_if.in_ready, 1);
        check("ar_taps", a_if.out_taps, 0);
        #1;
        rst = 1'b1;
        a_if.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            a_if.in_valid = 1'b1; a_if.in_ch = 2'd1; a_if.in_data = sample_t'(400 + k);
            tick();
            check("ar_fill_valid", a_if.out_valid, (k == 8) ? 1 : 0);
            if (k == 8) begin
                check("ar_fill_ch", a_if.out_ch, 1);
                check("ar_fill_taps", a_if.out_taps, win(408));
            end
        end
        a_if.in_valid = 1'b0;

        // Decimation by 3 on instance B: windows after samples 8, 11, 14
        for (int i = 1; i <= 14; i++) begin
            b_if.in_valid = 1'b1; b_if.in_ch = 1'b0; b_if.in_data = sample_t'(i);
            tick();
            check("dec_valid", b_if.out_valid, (i == 8 || i == 11 || i == 14) ? 1 : 0);
            if (i == 8 || i == 11 || i == 14) begin
                check("dec_taps", b_if.out_taps, win(i));
            end
        end
        b_if.in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
